// File: rtl/mandel_pkg.sv
// -----------------------------------------------------------------------------
// mandel_pkg
//  Shared constants and types for the Mandelbrot view pipeline.
//  COORD_WIDTH/GUARD define the Q4.12 coordinate format and the extra internal
//  fraction bits carried by the coordinate accumulators. BASE_STEP is the
//  per-pixel step at zoom 0 in internal units (4.0/640 * 2^20).
//  No ports (package).
// -----------------------------------------------------------------------------
package mandel_pkg;

   localparam int COORD_WIDTH = 16;
   localparam int ZOOM_WIDTH  = 8;
   localparam int GUARD       = 8;
   localparam int BASE_STEP   = 6554;
   localparam int H_RES       = 640;
   localparam int V_RES       = 480;
   localparam int MAX_ZOOM    = 15;

   // Signed Q4.12 coordinate as seen on the module boundaries.
   typedef logic signed [COORD_WIDTH-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STREAM = 2'd2
   } coord_state_e;

endpackage

// File: rtl/mandel_raster_cnt.sv
// -----------------------------------------------------------------------------
// mandel_raster_cnt
//  Pixel/line counters for the coordinate stream, raster order.
//  Optional build macro: MANDEL_COORD_PIXTAG_EN exposes the raw px/py counts.
// Ports
//  clk      in   clock
//  rst_n    in   asynchronous reset, active-low
//  clear    in   synchronous return to pixel (0,0)
//  advance  in   one pixel transferred
//  eol      out  px is on the last pixel of the line
//  eof      out  px/py is on the last pixel of the frame
//  px, py   out  current pixel position (MANDEL_COORD_PIXTAG_EN only)
// -----------------------------------------------------------------------------
module mandel_raster_cnt #(
   parameter int H_RES = mandel_pkg::H_RES,
   parameter int V_RES = mandel_pkg::V_RES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic advance,
   output logic eol,
   output logic eof
`ifdef MANDEL_COORD_PIXTAG_EN
   ,
   output logic [$clog2(H_RES)-1:0] px,
   output logic [$clog2(V_RES)-1:0] py
`endif
);

   localparam int PXW = $clog2(H_RES);
   localparam int PYW = $clog2(V_RES);

   logic [PXW-1:0] px_reg;
   logic [PYW-1:0] py_reg;

   always_comb begin
      eol = (px_reg == PXW'(H_RES - 1));
      eof = eol && (py_reg == PYW'(V_RES - 1));
   end

   // The last transfer of a frame wraps both counters to zero, so the next
   // frame always starts from (0,0) without an explicit clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_reg <= '0;
         py_reg <= '0;
      end else if (clear) begin
         px_reg <= '0;
         py_reg <= '0;
      end else if (advance) begin
         if (eol) begin
            px_reg <= '0;
            py_reg <= eof ? '0 : py_reg + 1'b1;
         end else begin
            px_reg <= px_reg + 1'b1;
         end
      end
   end

`ifdef MANDEL_COORD_PIXTAG_EN
   assign px = px_reg;
   assign py = py_reg;
`endif

endmodule

// File: rtl/mandel_coord_gen.sv
// -----------------------------------------------------------------------------
// mandel_coord_gen
//  Turns the latched view parameters (centre, zoom) into one complex
//  coordinate c = (c_re, c_im) per screen pixel, in raster order.
//  On v_begin the inputs are latched; the top-left origin is then computed by
//  repeated subtraction (no multiplier) during SETUP, and pixels stream out
//  over a valid/ready handshake during STREAM.
//  Optional build macro: MANDEL_COORD_PIXTAG_EN adds pix_x/pix_y outputs.
// Ports
//  clk          in   clock
//  rst_n        in   asynchronous reset, active-low
//  v_begin      in   frame-start strobe; aborts any frame in progress
//  centre_x/y   in   signed Q4.12 view centre
//  zoom_level   in   zoom exponent, clamped to 15
//  coord_valid  out  c_re/c_im hold a valid pixel coordinate
//  coord_ready  in   downstream accepts (transfer on valid && ready)
//  c_re/c_im    out  signed Q4.12 pixel coordinate
//  busy         out  SETUP or STREAM
//  frame_done   out  one-cycle pulse after the last pixel transfer
//  pix_x/pix_y  out  pixel position aligned with c_re/c_im (optional)
// -----------------------------------------------------------------------------
module mandel_coord_gen #(
   parameter int COORD_WIDTH = mandel_pkg::COORD_WIDTH,
   parameter int ZOOM_WIDTH  = mandel_pkg::ZOOM_WIDTH,
   parameter int H_RES       = mandel_pkg::H_RES,
   parameter int V_RES       = mandel_pkg::V_RES,
   parameter int GUARD       = mandel_pkg::GUARD,
   parameter int BASE_STEP   = mandel_pkg::BASE_STEP
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   v_begin,
   input  logic [COORD_WIDTH-1:0] centre_x,
   input  logic [COORD_WIDTH-1:0] centre_y,
   input  logic [ZOOM_WIDTH-1:0]  zoom_level,
   output logic                   coord_valid,
   input  logic                   coord_ready,
   output logic [COORD_WIDTH-1:0] c_re,
   output logic [COORD_WIDTH-1:0] c_im,
   output logic                   busy,
   output logic                   frame_done
`ifdef MANDEL_COORD_PIXTAG_EN
   ,
   output logic [$clog2(H_RES)-1:0] pix_x,
   output logic [$clog2(V_RES)-1:0] pix_y
`endif
);

   import mandel_pkg::*;

   localparam int AW     = COORD_WIDTH + GUARD;
   localparam int HALF_H = H_RES / 2;
   localparam int HALF_V = V_RES / 2;
   localparam int SW     = $clog2(HALF_H + 1);

   coord_state_e state_reg, state_next;

   logic [SW-1:0] setup_cnt_reg;
   logic [AW-1:0] ox_reg, oy_reg, step_reg;
   logic [AW-1:0] acc_re_reg, acc_im_reg;
   logic          valid_reg, frame_done_reg;

   logic [3:0]    zoom_eff;
   logic [AW-1:0] step_shift, step_latch;
   logic          setup_done, xfer, last_xfer;
   logic          eol, eof;

   // Step for the zoom presented with v_begin; never allowed to reach zero
   // so that deep zooms still move across the plane.
   always_comb begin
      zoom_eff   = (zoom_level > ZOOM_WIDTH'(MAX_ZOOM)) ? 4'(MAX_ZOOM) : zoom_level[3:0];
      step_shift = AW'(BASE_STEP) >> zoom_eff;
      step_latch = (step_shift == '0) ? AW'(1) : step_shift;
   end

   // SETUP spends HALF_H cycles subtracting the step (the vertical origin
   // only for the first HALF_V of them, which is why H_RES >= V_RES), then
   // one more cycle loading the accumulators and raising valid.
   always_comb begin
      setup_done = (state_reg == SETUP) && (setup_cnt_reg == SW'(HALF_H));
      xfer       = valid_reg && coord_ready;
      last_xfer  = xfer && eof;
   end

   mandel_raster_cnt #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_raster (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (v_begin),
      .advance (xfer),
      .eol     (eol),
      .eof     (eof)
`ifdef MANDEL_COORD_PIXTAG_EN
      ,
      .px      (pix_x),
      .py      (pix_y)
`endif
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_next = state_reg;
      if (v_begin) begin
         state_next = SETUP;
      end else begin
         case (state_reg)
            IDLE:    state_next = IDLE;
            SETUP:   if (setup_done) state_next = STREAM;
            STREAM:  if (last_xfer)  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy = (state_reg == SETUP) || (state_reg == STREAM);
   end

   // ---- Datapath ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         setup_cnt_reg  <= '0;
         ox_reg         <= '0;
         oy_reg         <= '0;
         step_reg       <= '0;
         acc_re_reg     <= '0;
         acc_im_reg     <= '0;
         valid_reg      <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         if (v_begin) begin
            // Abort anything in flight; the accumulators keep their stale
            // value but valid is dropped so nobody consumes it.
            ox_reg        <= {centre_x, {GUARD{1'b0}}};
            oy_reg        <= {centre_y, {GUARD{1'b0}}};
            step_reg      <= step_latch;
            setup_cnt_reg <= '0;
            valid_reg     <= 1'b0;
         end else begin
            case (state_reg)
               SETUP: begin
                  if (setup_cnt_reg < SW'(HALF_H)) begin
                     ox_reg <= ox_reg - step_reg;
                     if (setup_cnt_reg < SW'(HALF_V))
                        oy_reg <= oy_reg - step_reg;
                     setup_cnt_reg <= setup_cnt_reg + 1'b1;
                  end else begin
                     acc_re_reg <= ox_reg;
                     acc_im_reg <= oy_reg;
                     valid_reg  <= 1'b1;
                  end
               end
               STREAM: begin
                  if (xfer) begin
                     if (eol) begin
                        acc_re_reg <= ox_reg;
                        acc_im_reg <= acc_im_reg + step_reg;
                     end else begin
                        acc_re_reg <= acc_re_reg + step_reg;
                     end
                     if (eof) begin
                        valid_reg      <= 1'b0;
                        frame_done_reg <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Dropping the guard bits of a two's-complement value is an arithmetic
   // shift, i.e. floor towards minus infinity.
   assign c_re        = acc_re_reg[AW-1:GUARD];
   assign c_im        = acc_im_reg[AW-1:GUARD];
   assign coord_valid = valid_reg;
   assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_mandel_coord_gen.sv
module tb_mandel_coord_gen;

   localparam int SH = 16;
   localparam int SV = 8;
   localparam int FH = 640;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v_begin = 1'b0;
   logic        coord_ready = 1'b0;
   logic [15:0] centre_x = '0;
   logic [15:0] centre_y = '0;
   logic [7:0]  zoom_level = '0;

   logic        f_valid, f_busy, f_done;
   logic [15:0] f_re, f_im;
   logic        s_valid, s_busy, s_done;
   logic [15:0] s_re, s_im;
`ifdef MANDEL_COORD_PIXTAG_EN
   logic [9:0]  f_px;
   logic [8:0]  f_py;
   logic [3:0]  s_px;
   logic [2:0]  s_py;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] cur_cx, cur_cy;
   int          cur_z;

   always #5 clk = ~clk;

   // Full-size instance (640x480) for the absolute reference values.
   mandel_coord_gen u_full (
      .clk         (clk),
      .rst_n       (rst_n),
      .v_begin     (v_begin),
      .centre_x    (centre_x),
      .centre_y    (centre_y),
      .zoom_level  (zoom_level),
      .coord_valid (f_valid),
      .coord_ready (coord_ready),
      .c_re        (f_re),
      .c_im        (f_im),
      .busy        (f_busy),
      .frame_done  (f_done)
`ifdef MANDEL_COORD_PIXTAG_EN
      ,
      .pix_x       (f_px),
      .pix_y       (f_py)
`endif
   );

   // Small instance (16x8) so whole frames fit in a short run.
   mandel_coord_gen #(.H_RES(SH), .V_RES(SV)) u_small (
      .clk         (clk),
      .rst_n       (rst_n),
      .v_begin     (v_begin),
      .centre_x    (centre_x),
      .centre_y    (centre_y),
      .zoom_level  (zoom_level),
      .coord_valid (s_valid),
      .coord_ready (coord_ready),
      .c_re        (s_re),
      .c_im        (s_im),
      .busy        (s_busy),
      .frame_done  (s_done)
`ifdef MANDEL_COORD_PIXTAG_EN
      ,
      .pix_x       (s_px),
      .pix_y       (s_py)
`endif
   );

   // Reference: coordinate along one axis = centre - step*half + step*pos,
   // computed directly in wide integers, wrapped to 24 bits, floored to Q4.12.
   function automatic logic [15:0] model_axis(input logic [15:0] centre, input int z,
                                              input int half, input int pos);
      int          zc;
      longint      step;
      longint      v;
      logic [63:0] w;
      zc = (z > 15) ? 15 : z;
      step = longint'(6554 >> zc);
      if (step < 1) step = 1;
      v = longint'($signed(centre)) * 256 - step * half + step * pos;
      w = v;
      return w[23:8];
   endfunction

   function automatic logic [15:0] s_exp_re(input int idx);
      return model_axis(cur_cx, cur_z, SH / 2, idx % SH);
   endfunction

   function automatic logic [15:0] s_exp_im(input int idx);
      return model_axis(cur_cy, cur_z, SV / 2, idx / SH);
   endfunction

   // Called at a falling edge; returns at the falling edge after v_begin was
   // sampled. Inputs are scrambled afterwards: they must not matter any more.
   task automatic start_frame(input logic [15:0] cx, input logic [15:0] cy, input int z);
      cur_cx = cx; cur_cy = cy; cur_z = z;
      centre_x = cx; centre_y = cy; zoom_level = 8'(z);
      v_begin = 1'b1;
      @(negedge clk);
      v_begin = 1'b0;
      centre_x = 16'($urandom); centre_y = 16'($urandom); zoom_level = 8'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_re !== 16'h0 || s_im !== 16'h0 ||
          f_valid !== 1'b0 || f_busy !== 1'b0 || f_done !== 1'b0 || f_re !== 16'h0 || f_im !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: s v=%b b=%b d=%b re=%h im=%h f v=%b b=%b d=%b re=%h im=%h, want all 0",
                  s_valid, s_busy, s_done, s_re, s_im, f_valid, f_busy, f_done, f_re, f_im);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (s_busy !== 1'b0 || f_busy !== 1'b0 || s_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: s_busy=%b f_busy=%b s_valid=%b, want 0", s_busy, f_busy, s_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_origin();
      int lat;
      int idx;
      coord_ready = 1'b0;
      start_frame(16'hF000, 16'h0000, 0);
      checks++;
      if (f_busy !== 1'b1 || f_valid !== 1'b0) begin
         errors++;
         $display("FAIL setup_busy: busy=%b valid=%b, want 1/0", f_busy, f_valid);
      end
      lat = 0;
      while (!f_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 321) begin
         errors++;
         $display("FAIL valid_latency_full: got %0d cycles, want 321", lat);
      end
      checks++;
      if (f_re !== 16'hCFFF || f_im !== 16'hE7FF) begin
         errors++;
         $display("FAIL first_pixel_full: got (%h,%h), want (cfff,e7ff)", f_re, f_im);
      end
      coord_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (f_re !== 16'hD019) begin
         errors++;
         $display("FAIL second_pixel_full: c_re=%h, want d019", f_re);
      end
      idx = 1;
      while (idx < FH) begin
         @(negedge clk);
         idx++;
      end
      checks++;
      if (f_valid !== 1'b1 || f_re !== 16'hCFFF || f_im !== model_axis(16'h0000, 0, 240, 1) ||
          f_done !== 1'b0) begin
         errors++;
         $display("FAIL pixel640_full: v=%b d=%b c=(%h,%h), want v=1 d=0 c=(cfff,%h)",
                  f_valid, f_done, f_re, f_im, model_axis(16'h0000, 0, 240, 1));
      end
      coord_ready = 1'b0;
      $display("test_origin done: pixel %0d reached", idx);
   endtask

   task automatic test_full_frame(input int n_frames);
      int lat;
      int idx;
      int cyc;
      logic xfer;
      for (int f = 0; f < n_frames; f++) begin
         coord_ready = 1'b0;
         start_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 17)));
         lat = 0;
         while (!s_valid && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         checks++;
         if (lat != SH / 2 + 1) begin
            errors++;
            $display("FAIL valid_latency_small: got %0d, want %0d", lat, SH / 2 + 1);
         end
         idx = 0;
         cyc = 0;
         while (idx < SH * SV && cyc < 4000) begin
            checks++;
            if (s_valid !== 1'b1 || s_done !== 1'b0) begin
               errors++;
               $display("FAIL stream_flags: idx=%0d valid=%b done=%b, want 1/0", idx, s_valid, s_done);
            end
            checks++;
            if (s_re !== s_exp_re(idx) || s_im !== s_exp_im(idx)) begin
               errors++;
               $display("FAIL pixel_value: idx=%0d got (%h,%h), want (%h,%h)",
                        idx, s_re, s_im, s_exp_re(idx), s_exp_im(idx));
            end
`ifdef MANDEL_COORD_PIXTAG_EN
            checks++;
            if (s_px !== 4'(idx % SH) || s_py !== 3'(idx / SH)) begin
               errors++;
               $display("FAIL pixtag: idx=%0d got (%0d,%0d), want (%0d,%0d)",
                        idx, s_px, s_py, idx % SH, idx / SH);
            end
`endif
            xfer = ($urandom_range(0, 3) != 0);
            coord_ready = xfer;
            @(negedge clk);
            cyc++;
            if (xfer) idx++;
         end
         checks++;
         if (idx != SH * SV) begin
            errors++;
            $display("FAIL frame_transfers: got %0d, want %0d", idx, SH * SV);
         end
         checks++;
         if (s_done !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse: done=%b valid=%b, want 1/0", s_done, s_valid);
         end
         coord_ready = 1'b0;
         @(negedge clk);
         checks++;
         if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL after_frame: done=%b busy=%b, want 0/0", s_done, s_busy);
         end
         $display("frame %0d: cx=%h cy=%h z=%0d transfers=%0d cycles=%0d", f, cur_cx, cur_cy, cur_z, idx, cyc);
      end
   endtask

   task automatic test_stall();
      int lat;
      int idx;
      coord_ready = 1'b0;
      start_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
      lat = 0;
      while (!s_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      coord_ready = 1'b1;
      idx = 0;
      repeat (5) begin
         @(negedge clk);
         idx++;
      end
      coord_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (s_valid !== 1'b1 || s_re !== s_exp_re(idx) || s_im !== s_exp_im(idx)) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d v=%b c=(%h,%h), want v=1 c=(%h,%h)",
                     i, s_valid, s_re, s_im, s_exp_re(idx), s_exp_im(idx));
         end
      end
      coord_ready = 1'b1;
      @(negedge clk);
      idx++;
      coord_ready = 1'b0;
      checks++;
      if (s_valid !== 1'b1 || s_re !== s_exp_re(idx) || s_im !== s_exp_im(idx)) begin
         errors++;
         $display("FAIL stall_resume: v=%b c=(%h,%h), want v=1 c=(%h,%h)",
                  s_valid, s_re, s_im, s_exp_re(idx), s_exp_im(idx));
      end
      $display("test_stall done: resumed at pixel %0d", idx);
   endtask

   task automatic test_zoom();
      int zl [2] = '{200, 3};
      int lat;
      logic [15:0] p0, p1;
      int diff;
      for (int k = 0; k < 2; k++) begin
         coord_ready = 1'b0;
         start_frame(16'($urandom), 16'($urandom), zl[k]);
         lat = 0;
         while (!s_valid && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         p0 = s_re;
         checks++;
         if (p0 !== s_exp_re(0) || s_im !== s_exp_im(0)) begin
            errors++;
            $display("FAIL zoom_pixel0: z=%0d got (%h,%h), want (%h,%h)",
                     zl[k], p0, s_im, s_exp_re(0), s_exp_im(0));
         end
         coord_ready = 1'b1;
         @(negedge clk);
         coord_ready = 1'b0;
         p1 = s_re;
         checks++;
         if (p1 !== s_exp_re(1)) begin
            errors++;
            $display("FAIL zoom_pixel1: z=%0d c_re=%h, want %h", zl[k], p1, s_exp_re(1));
         end
         diff = int'($signed(p1 - p0));
         checks++;
         if ((zl[k] == 3 && (diff < 3 || diff > 4)) || (zl[k] == 200 && (diff < 0 || diff > 1))) begin
            errors++;
            $display("FAIL zoom_delta: z=%0d c_re delta=%0d, want %s", zl[k], diff,
                     (zl[k] == 3) ? "3..4" : "0..1");
         end
         $display("zoom %0d: pixel0=%h pixel1=%h delta=%0d", zl[k], p0, p1, diff);
      end
   endtask

   task automatic test_abort();
      int lat;
      int idx;
      logic done_seen;
      coord_ready = 1'b0;
      start_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
      lat = 0;
      while (!s_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      coord_ready = 1'b1;
      idx = 0;
      while (idx < 50) begin
         @(negedge clk);
         idx++;
      end
      start_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
      coord_ready = 1'b0;
      checks++;
      if (s_valid !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_drop: valid=%b done=%b busy=%b, want 0/0/1", s_valid, s_done, s_busy);
      end
      lat = 0;
      done_seen = 1'b0;
      while (!s_valid && lat < 50) begin
         @(negedge clk);
         lat++;
         if (s_done) done_seen = 1'b1;
      end
      checks++;
      if (lat != SH / 2 + 1 || done_seen) begin
         errors++;
         $display("FAIL abort_restart: latency=%0d done_seen=%b, want %0d/0", lat, done_seen, SH / 2 + 1);
      end
      checks++;
      if (s_re !== s_exp_re(0) || s_im !== s_exp_im(0)) begin
         errors++;
         $display("FAIL abort_first_pixel: got (%h,%h), want (%h,%h)", s_re, s_im, s_exp_re(0), s_exp_im(0));
      end
      $display("test_abort done: aborted at pixel %0d, restart latency %0d", idx, lat);
   endtask

   task automatic test_async_reset();
      int lat;
      coord_ready = 1'b0;
      start_frame(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)));
      lat = 0;
      while (!s_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      coord_ready = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0 || s_re !== 16'h0 || s_im !== 16'h0 ||
          f_valid !== 1'b0 || f_busy !== 1'b0 || f_re !== 16'h0 || f_im !== 16'h0) begin
         errors++;
         $display("FAIL async_reset: s v=%b b=%b d=%b c=(%h,%h) f v=%b b=%b c=(%h,%h), want all 0",
                  s_valid, s_busy, s_done, s_re, s_im, f_valid, f_busy, f_re, f_im);
      end
`ifdef MANDEL_COORD_PIXTAG_EN
      checks++;
      if (s_px !== '0 || s_py !== '0 || f_px !== '0 || f_py !== '0) begin
         errors++;
         $display("FAIL async_reset_pixtag: s=(%0d,%0d) f=(%0d,%0d), want 0", s_px, s_py, f_px, f_py);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || f_valid !== 1'b0 || f_busy !== 1'b0) begin
         errors++;
         $display("FAIL no_restart_without_vbegin: s v=%b b=%b f v=%b b=%b, want 0",
                  s_valid, s_busy, f_valid, f_busy);
      end
      coord_ready = 1'b0;
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_origin();
      test_full_frame(3);
      test_stall();
      test_zoom();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
